// File: rtl/pr_read_arbiter.sv
// Round-robin AXI read-channel arbiter for the PageRank vertex (ARID 0) and in-edge (ARID 1) fetchers.
// Optional PR_ARB_STATS_EN adds saturating grant/stall counters; otherwise the stat ports read 0.
module pr_read_arbiter #(
  parameter int         MAX_OUT = 8,
  parameter logic [2:0] ARSIZE0 = 3'b011,
  parameter logic [2:0] ARSIZE1 = 3'b011
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [63:0]  req0_addr,
  input  logic [7:0]   req0_len,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [63:0]  req1_addr,
  input  logic [7:0]   req1_len,
  output logic         req1_ready,
  output logic         resp0_valid,
  output logic [511:0] resp0_data,
  output logic         resp0_last,
  input  logic         resp0_ready,
  output logic         resp1_valid,
  output logic [511:0] resp1_data,
  output logic         resp1_last,
  input  logic         resp1_ready,
  output logic [15:0]  arid_m,
  output logic [63:0]  araddr_m,
  output logic [7:0]   arlen_m,
  output logic [2:0]   arsize_m,
  output logic         arvalid_m,
  input  logic         arready_m,
  input  logic [15:0]  rid_m,
  input  logic [511:0] rdata_m,
  input  logic [1:0]   rresp_m,
  input  logic         rlast_m,
  input  logic         rvalid_m,
  output logic         rready_m,
  output logic         err,
  output logic [7:0]   out0,
  output logic [7:0]   out1,
  output logic [31:0]  stat_grant0,
  output logic [31:0]  stat_grant1,
  output logic [31:0]  stat_stall
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t state;
  logic   last_grant;
  logic   elig0, elig1, pick1;
  logic   ar_accept, inc0, inc1;
  logic   rid_known, r_fire, ret0, ret1, bad_rid;
  logic [8:0] cred0, cred1;

  // Returns {underflow, next_count}; a simultaneous issue and return cancel out.
  function automatic logic [8:0] credit_next(input logic [7:0] cnt, input logic inc,
                                             input logic ret);
    logic [8:0] res;
    res = {1'b0, cnt};
    if (inc && !ret)
      res = {1'b0, cnt + 8'd1};
    else if (ret && !inc) begin
      if (cnt == 8'd0) res = {1'b1, 8'd0};
      else             res = {1'b0, cnt - 8'd1};
    end
    return res;
  endfunction

  assign elig0 = req0_valid && (out0 < 8'(MAX_OUT));
  assign elig1 = req1_valid && (out1 < 8'(MAX_OUT));
  // On a tie the requester that did not win last time goes next.
  assign pick1 = elig1 && (!elig0 || !last_grant);

  // NOTE: the ready pulses are decoded from the live AR handshake rather than registered,
  // so the requester sees ready in exactly the cycle its address is taken.
  assign ar_accept  = (state == ISSUE) && arvalid_m && arready_m;
  assign inc0       = ar_accept && !arid_m[0];
  assign inc1       = ar_accept &&  arid_m[0];
  assign req0_ready = inc0;
  assign req1_ready = inc1;

  assign rid_known  = (rid_m[15:1] == 15'd0);
  assign resp0_data = rdata_m;
  assign resp1_data = rdata_m;
  assign resp0_last = rlast_m;
  assign resp1_last = rlast_m;

  // NOTE: every signal gets a default before the branches so no latch is inferred.
  always_comb begin
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    rready_m    = 1'b1;
    if (rid_known && !rid_m[0]) begin
      resp0_valid = rvalid_m;
      rready_m    = resp0_ready;
    end else if (rid_known) begin
      resp1_valid = rvalid_m;
      rready_m    = resp1_ready;
    end
  end

  assign r_fire  = rvalid_m && rready_m;
  assign ret0    = r_fire && rlast_m && rid_known && !rid_m[0];
  assign ret1    = r_fire && rlast_m && rid_known &&  rid_m[0];
  assign bad_rid = rvalid_m && !rid_known;
  assign cred0   = credit_next(out0, inc0, ret0);
  assign cred1   = credit_next(out1, inc1, ret1);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      arvalid_m  <= 1'b0;
      araddr_m   <= '0;
      arid_m     <= '0;
      arlen_m    <= '0;
      arsize_m   <= ARSIZE0;
      last_grant <= 1'b1;
      out0       <= '0;
      out1       <= '0;
      err        <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (elig0 || elig1) begin
          arvalid_m <= 1'b1;
          arid_m    <= {15'd0, pick1};
          araddr_m  <= pick1 ? req1_addr : req0_addr;
          arlen_m   <= pick1 ? req1_len  : req0_len;
          arsize_m  <= pick1 ? ARSIZE1   : ARSIZE0;
          state     <= ISSUE;
        end
      end else if (arready_m) begin
        arvalid_m  <= 1'b0;
        last_grant <= arid_m[0];
        state      <= IDLE;
      end
      out0 <= cred0[7:0];
      out1 <= cred1[7:0];
      if (bad_rid || (r_fire && rresp_m != 2'b00) || cred0[8] || cred1[8])
        err <= 1'b1;
    end
  end

`ifdef PR_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
      stat_stall  <= '0;
    end else begin
      if (inc0 && stat_grant0 != '1) stat_grant0 <= stat_grant0 + 32'd1;
      if (inc1 && stat_grant1 != '1) stat_grant1 <= stat_grant1 + 32'd1;
      if (arvalid_m && !arready_m && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
    end
  end
`else
  assign stat_grant0 = '0;
  assign stat_grant1 = '0;
  assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_pr_read_arbiter.sv
// Directed bench for pr_read_arbiter: AR expectations are queued when a request is driven
// and popped when the AR handshake appears; R routing, credits and err are checked inline.
module tb_pr_read_arbiter;

  localparam int         MAX_OUT = 8;
  localparam logic [2:0] AS0 = 3'b011;
  localparam logic [2:0] AS1 = 3'b010;

  logic         clk, rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [63:0]  req0_addr, req1_addr;
  logic [7:0]   req0_len, req1_len;
  logic         resp0_valid, resp0_last, resp0_ready;
  logic         resp1_valid, resp1_last, resp1_ready;
  logic [511:0] resp0_data, resp1_data;
  logic [15:0]  arid_m, rid_m;
  logic [63:0]  araddr_m;
  logic [7:0]   arlen_m;
  logic [2:0]   arsize_m;
  logic         arvalid_m, arready_m;
  logic [511:0] rdata_m;
  logic [1:0]   rresp_m;
  logic         rlast_m, rvalid_m, rready_m, err;
  logic [7:0]   out0, out1;
  logic [31:0]  stat_grant0, stat_grant1, stat_stall;

  pr_read_arbiter #(.MAX_OUT(MAX_OUT), .ARSIZE0(AS0), .ARSIZE1(AS1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_last(resp0_last),
    .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_last(resp1_last),
    .resp1_ready(resp1_ready),
    .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
    .arvalid_m(arvalid_m), .arready_m(arready_m),
    .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m),
    .rvalid_m(rvalid_m), .rready_m(rready_m),
    .err(err), .out0(out0), .out1(out1),
    .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_stall(stat_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [63:0] addr;
    logic [7:0]  len;
  } ar_t;

  ar_t ar_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_fail   = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_ar(input logic id, input logic [63:0] addr, input logic [7:0] len);
    ar_t e;
    e.id = id; e.addr = addr; e.len = len;
    ar_q.push_back(e);
  endtask

  task automatic check_stats(input string tag, input int g0, input int g1, input int st);
`ifdef PR_ARB_STATS_EN
    check({tag, "_grant0"}, stat_grant0, g0);
    check({tag, "_grant1"}, stat_grant1, g1);
    check({tag, "_stall"},  stat_stall,  st);
`else
    check({tag, "_grant0"}, stat_grant0, 0);
    check({tag, "_grant1"}, stat_grant1, 0);
    check({tag, "_stall"},  stat_stall,  0);
`endif
  endtask

  // Called at a negedge; returns just after the negedge on which an AR handshake is visible.
  task automatic await_accept(input int budget, output int cycles, output logic id);
    ar_t e;
    cycles = -1;
    id = 1'b0;
    for (int c = 0; c < budget; c++) begin
      #1;
      if (arvalid_m && arready_m) begin
        cycles = c;
        id = arid_m[0];
        check("ar_expected", ar_q.size() != 0, 1'b1);
        if (ar_q.size() == 0) return;
        e = ar_q.pop_front();
        check("arid",       arid_m,     {15'd0, e.id});
        check("araddr",     araddr_m,   e.addr);
        check("arlen",      arlen_m,    e.len);
        check("arsize",     arsize_m,   e.id ? AS1 : AS0);
        check("req0_ready", req0_ready, !e.id);
        check("req1_ready", req1_ready, e.id);
        return;
      end
      @(negedge clk);
    end
    check("ar_timeout", arvalid_m && arready_m, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int   cyc;
    logic gid;
    int   a0, a1;

    rst = 1'b1;
    req0_valid = 0; req0_addr = '0; req0_len = '0;
    req1_valid = 0; req1_addr = '0; req1_len = '0;
    resp0_ready = 0; resp1_ready = 0;
    arready_m = 0; rid_m = '0; rdata_m = '0; rresp_m = '0; rlast_m = 0; rvalid_m = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_arvalid", arvalid_m, 1'b0);
    check("rst_araddr",  araddr_m,  64'd0);
    check("rst_arid",    arid_m,    16'd0);
    check("rst_arlen",   arlen_m,   8'd0);
    check("rst_arsize",  arsize_m,  AS0);
    check("rst_ready",   {req1_ready, req0_ready}, 2'b00);
    check("rst_err",     err,  1'b0);
    check("rst_out",     {out1, out0}, 16'd0);
    rst = 1'b0;

    // T1: single req0 burst, one-cycle issue latency, credit out and back
    @(negedge clk);
    req0_valid = 1; req0_addr = 64'h40; req0_len = 8'd0; arready_m = 1;
    exp_ar(1'b0, 64'h40, 8'd0);
    await_accept(8, cyc, gid);
    check("t1_latency", cyc, 1);
    @(negedge clk);
    req0_valid = 0;
    #1;
    check("t1_out0", out0, 8'd1);
    check("t1_arvalid_drop", arvalid_m, 1'b0);
    check_stats("t1", 1, 0, 0);
    rvalid_m = 1; rid_m = 16'd0; rlast_m = 1; rdata_m = {16{32'hCAFE_0001}}; resp0_ready = 1;
    #1;
    check("t1_resp0_valid", resp0_valid, 1'b1);
    check("t1_resp1_valid", resp1_valid, 1'b0);
    check("t1_rready",      rready_m,    1'b1);
    check("t1_resp0_data",  resp0_data,  {16{32'hCAFE_0001}});
    check("t1_resp0_last",  resp0_last,  1'b1);
    @(negedge clk);
    rvalid_m = 0;
    #1;
    check("t1_out0_ret", out0, 8'd0);
    check("t1_err",      err,  1'b0);

    // T3: req1 address held stable through a 5-cycle AR stall
    @(negedge clk);
    req1_valid = 1; req1_addr = 64'h80; req1_len = 8'd3; arready_m = 0;
    exp_ar(1'b1, 64'h80, 8'd3);
    @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      #1;
      check("t3_arvalid", arvalid_m, 1'b1);
      check("t3_araddr",  araddr_m,  64'h80);
      check("t3_arid",    arid_m,    16'd1);
      check("t3_ready",   {req1_ready, req0_ready}, 2'b00);
      @(negedge clk);
    end
    arready_m = 1;
    await_accept(4, cyc, gid);
    check("t3_accept_now", cyc, 0);
    @(negedge clk);
    req1_valid = 0;
    #1;
    check("t3_out1", out1, 8'd1);
    check_stats("t3", 1, 1, 5);

    // T4: back-pressure on requester 1 propagates to rready_m
    @(negedge clk);
    rvalid_m = 1; rid_m = 16'd1; rlast_m = 1; rdata_m = {8{64'h1234_5678_9ABC_DEF0}};
    resp1_ready = 0; resp0_ready = 1;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("t4_rready_low",  rready_m,    1'b0);
      check("t4_resp1_valid", resp1_valid, 1'b1);
      check("t4_resp0_valid", resp0_valid, 1'b0);
      @(negedge clk);
    end
    check("t4_out1_held", out1, 8'd1);
    resp1_ready = 1;
    #1;
    check("t4_rready_high", rready_m,   1'b1);
    check("t4_resp1_data",  resp1_data, {8{64'h1234_5678_9ABC_DEF0}});
    @(negedge clk);
    rvalid_m = 0;
    #1;
    check("t4_out1_ret", out1, 8'd0);

    // T5: unknown RID is dropped and flags err; error response still delivered
    rvalid_m = 1; rid_m = 16'd5; rlast_m = 1;
    #1;
    check("t5_rready",      rready_m, 1'b1);
    check("t5_no_resp",     {resp1_valid, resp0_valid}, 2'b00);
    check("t5_err_before",  err, 1'b0);
    @(negedge clk);
    rvalid_m = 0;
    #1;
    check("t5_err_set", err, 1'b1);
    check("t5_out",     {out1, out0}, 16'd0);
    rvalid_m = 1; rid_m = 16'd0; rresp_m = 2'd2; rlast_m = 0; rdata_m = {64{8'h5A}};
    resp0_ready = 1;
    #1;
    check("t5_slverr_valid", resp0_valid, 1'b1);
    check("t5_slverr_data",  resp0_data,  {64{8'h5A}});
    @(negedge clk);
    rvalid_m = 0; rresp_m = 2'd0;
    #1;
    check("t5_err_sticky", err, 1'b1);

    // T2: both requesters held valid -> strict alternation until both hit MAX_OUT
    @(negedge clk);
    a0 = 0; a1 = 0;
    req0_addr = 64'h1000; req0_len = 8'd1; req1_addr = 64'h2000; req1_len = 8'd7;
    req0_valid = 1; req1_valid = 1; arready_m = 1;
    for (int k = 0; k < MAX_OUT; k++) begin
      exp_ar(1'b0, 64'h1000 + 64'(k) * 64'h40, 8'd1);
      exp_ar(1'b1, 64'h2000 + 64'(k) * 64'h40, 8'd7);
    end
    for (int g = 0; g < 2 * MAX_OUT; g++) begin
      await_accept(8, cyc, gid);
      @(negedge clk);
      if (gid) begin a1++; req1_addr = 64'h2000 + 64'(a1) * 64'h40; end
      else     begin a0++; req0_addr = 64'h1000 + 64'(a0) * 64'h40; end
    end
    for (int s = 0; s < 4; s++) begin
      #1;
      check("t2_capped_arvalid", arvalid_m, 1'b0);
      @(negedge clk);
    end
    check("t2_out0", out0, 8'(MAX_OUT));
    check("t2_out1", out1, 8'(MAX_OUT));
    check("t2_queue_drained", ar_q.size(), 0);
    check_stats("t2", MAX_OUT + 1, MAX_OUT + 1, 5);

    // T6: return 5 credits (req0 regains eligibility, parks in ISSUE), then reset
    req1_valid = 0; arready_m = 0;
    rvalid_m = 1; rid_m = 16'd0; rlast_m = 1; resp0_ready = 1;
    repeat (5) @(negedge clk);
    rvalid_m = 0;
    #1;
    check("t6_out0_pre",    out0, 8'd3);
    check("t6_in_issue",    arvalid_m, 1'b1);
    check("t6_no_ready",    req0_ready, 1'b0);
    check("t6_err_pre",     err, 1'b1);
    rst = 1;
    @(negedge clk);
    #1;
    check("t6_arvalid", arvalid_m, 1'b0);
    check("t6_out",     {out1, out0}, 16'd0);
    check("t6_err",     err, 1'b0);
    check("t6_araddr",  araddr_m, 64'd0);
    check_stats("t6", 0, 0, 0);
    rst = 0; req0_valid = 0;
    repeat (2) @(negedge clk);
    #1;
    check("t6_idle", arvalid_m, 1'b0);

    // Underflow: an R-last with no outstanding burst flags err and leaves out0 at 0
    rvalid_m = 1; rid_m = 16'd0; rlast_m = 1; resp0_ready = 1;
    @(negedge clk);
    rvalid_m = 0;
    #1;
    check("uf_err",  err,  1'b1);
    check("uf_out0", out0, 8'd0);

    // Non-OKAY response on a mid-burst beat sets err from a clean state
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    check("rresp_err_clear", err, 1'b0);
    rvalid_m = 1; rid_m = 16'd1; rresp_m = 2'd1; rlast_m = 0; resp1_ready = 1;
    @(negedge clk);
    rvalid_m = 0; rresp_m = 2'd0;
    #1;
    check("rresp_err", err,  1'b1);
    check("rresp_out1", out1, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
